// File: rtl/if_id_stage_pkg.sv
// Shared constants and source-register decode helper for the IF/ID stage.
package if_id_stage_pkg;

    // RV32 major opcodes that affect which source registers an instruction reads
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    // Bubble encoding placed in the IF/ID latch on reset and squash
    localparam logic [31:0] NOP_IR_ENC = 32'h0000_0000;

    // Sequential fetch increment
    localparam logic [31:0] PC_STEP = 32'd4;

    // Source operands of an instruction and whether each one is really read
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } src_decode_t;

    // Decode which register fields an instruction actually reads
    function automatic src_decode_t decode_sources(input logic [31:0] ir);
        src_decode_t d;
        d.rs1 = ir[19:15];
        d.rs2 = ir[24:20];
        case (ir[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: d.use_rs1 = 1'b0;
            default:                  d.use_rs1 = 1'b1;
        endcase
        case (ir[6:0])
            OP_R, OP_S, OP_B: d.use_rs2 = 1'b1;
            default:          d.use_rs2 = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Combinational RAW hazard detection between the instruction in ID and the
// destination registers of the instructions currently in EX and MEM.
module hazard_detect
    import if_id_stage_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    output logic        hazard
);

    src_decode_t src_s;
    logic        ex_hit_s;
    logic        mem_hit_s;

    // Compare the used source registers against nonzero in-flight destinations
    always_comb begin
        src_s     = decode_sources(ir);
        ex_hit_s  = 1'b0;
        mem_hit_s = 1'b0;
        if (ex_regwrite && (ex_rd != 5'd0)) begin
            ex_hit_s = (src_s.use_rs1 && (src_s.rs1 == ex_rd)) ||
                       (src_s.use_rs2 && (src_s.rs2 == ex_rd));
        end else begin
            ex_hit_s = 1'b0;
        end
        if (mem_regwrite && (mem_rd != 5'd0)) begin
            mem_hit_s = (src_s.use_rs1 && (src_s.rs1 == mem_rd)) ||
                        (src_s.use_rs2 && (src_s.rs2 == mem_rd));
        end else begin
            mem_hit_s = 1'b0;
        end
        hazard = valid && (ex_hit_s || mem_hit_s);
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline latch: PC register, sequential
// fetch, redirect on taken branch/jump, RAW stall, and saturating counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR   = NOP_IR_ENC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_in,
    output logic [31:0]      IF_PC,
    output logic [31:0]      ID_IR,
    output logic [31:0]      ID_PCurrent,
    output logic             ID_valid,
    input  logic [4:0]       EX_rd,
    input  logic             EX_RegWrite,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_RegWrite,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             Data_stall,
    output logic             ctrl_flush,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_r;
    logic [31:0]      ir_r;
    logic [31:0]      pcur_r;
    logic             valid_r;
    logic [CNT_W-1:0] cnt_stall_r;
    logic [CNT_W-1:0] cnt_flush_r;

    logic             hazard_s;
    logic             stall_s;
    logic [31:0]      pc_plus_s;
    logic [31:0]      target_s;
    logic             unused_pc_low_s;

    hazard_detect u_hazard (
        .ir           (ir_r),
        .valid        (valid_r),
        .ex_rd        (EX_rd),
        .ex_regwrite  (EX_RegWrite),
        .mem_rd       (MEM_rd),
        .mem_regwrite (MEM_RegWrite),
        .hazard       (hazard_s)
    );

    // Stall only when not redirecting; a redirect squashes the hazarding instruction
    always_comb begin
        stall_s   = hazard_s && !redirect;
        pc_plus_s = pc_r + PC_STEP;
        target_s  = {redirect_pc[31:2], 2'b00};
    end

    // Low target bits are forced to word alignment and otherwise ignored
    assign unused_pc_low_s = ^redirect_pc[1:0];

    // PC and IF/ID latch update: reset > redirect > stall > sequential fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            ir_r    <= NOP_IR;
            pcur_r  <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (redirect) begin
            pc_r    <= target_s;
            ir_r    <= NOP_IR;
            pcur_r  <= pc_r;
            valid_r <= 1'b0;
        end else if (stall_s) begin
            pc_r    <= pc_r;
            ir_r    <= ir_r;
            pcur_r  <= pcur_r;
            valid_r <= valid_r;
        end else begin
            pc_r    <= pc_plus_s;
            ir_r    <= inst_in;
            pcur_r  <= pc_r;
            valid_r <= 1'b1;
        end
    end

    // Saturating stall and flush cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_stall_r <= {CNT_W{1'b0}};
            cnt_flush_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (cnt_stall_r != CNT_MAX)) begin
                cnt_stall_r <= cnt_stall_r + CNT_ONE;
            end else begin
                cnt_stall_r <= cnt_stall_r;
            end
            if (redirect && (cnt_flush_r != CNT_MAX)) begin
                cnt_flush_r <= cnt_flush_r + CNT_ONE;
            end else begin
                cnt_flush_r <= cnt_flush_r;
            end
        end
    end

    assign IF_PC       = pc_r;
    assign ID_IR       = ir_r;
    assign ID_PCurrent = pcur_r;
    assign ID_valid    = valid_r;
    assign Data_stall  = stall_s;
    assign ctrl_flush  = redirect;
    assign cnt_stall   = cnt_stall_r;
    assign cnt_flush   = cnt_flush_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios, randomized traffic
// against a behavioural model, and counter saturation on a narrow instance.
module tb_if_id_stage;

    localparam logic [31:0] ADD_X3_X1_X2 = 32'h0020_81B3;
    localparam logic [31:0] ADD_X3_X0_X2 = 32'h0020_01B3;
    localparam logic [31:0] LUI_X5_8     = 32'h0000_82B7;
    localparam logic [31:0] ADDI_NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_in;
    logic [31:0] IF_PC, ID_IR, ID_PCurrent;
    logic        ID_valid;
    logic [4:0]  EX_rd, MEM_rd;
    logic        EX_RegWrite, MEM_RegWrite, redirect;
    logic [31:0] redirect_pc;
    logic        Data_stall, ctrl_flush;
    logic [31:0] cnt_stall, cnt_flush;

    logic        s_rst;
    logic [31:0] s_inst;
    logic [31:0] s_if_pc, s_id_ir, s_id_pcur;
    logic        s_id_valid;
    logic [4:0]  s_ex_rd, s_mem_rd;
    logic        s_ex_we, s_mem_we, s_redirect;
    logic [31:0] s_redirect_pc;
    logic        s_stall, s_flush;
    logic [3:0]  s_cnt_stall, s_cnt_flush;

    int compared = 0;
    int failed   = 0;

    // behavioural model state
    logic [31:0] m_pc, m_ir, m_pcur;
    logic        m_valid;
    longint      m_cs, m_cf;
    // information about the step just taken, used by the downstream pipeline model
    logic        last_stall, last_valid;
    logic [31:0] last_ir;

    always #5 clk = ~clk;

    if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_IR(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .IF_PC(IF_PC), .ID_IR(ID_IR),
        .ID_PCurrent(ID_PCurrent), .ID_valid(ID_valid), .EX_rd(EX_rd),
        .EX_RegWrite(EX_RegWrite), .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite),
        .redirect(redirect), .redirect_pc(redirect_pc), .Data_stall(Data_stall),
        .ctrl_flush(ctrl_flush), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_IR(32'h0000_0000), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(s_rst), .inst_in(s_inst), .IF_PC(s_if_pc), .ID_IR(s_id_ir),
        .ID_PCurrent(s_id_pcur), .ID_valid(s_id_valid), .EX_rd(s_ex_rd),
        .EX_RegWrite(s_ex_we), .MEM_rd(s_mem_rd), .MEM_RegWrite(s_mem_we),
        .redirect(s_redirect), .redirect_pc(s_redirect_pc), .Data_stall(s_stall),
        .ctrl_flush(s_flush), .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // true when instruction ir reads architectural register r (x0 never counts)
    function automatic bit reads_reg(input logic [31:0] ir, input logic [4:0] r);
        logic [6:0] op;
        bit u1, u2;
        op = ir[6:0];
        u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (r != 5'd0) && ((u1 && ir[19:15] == r) || (u2 && ir[24:20] == r));
    endfunction

    function automatic bit writes_reg(input logic [31:0] ir);
        return !(ir[6:0] inside {7'b0100011, 7'b1100011});
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_pcur = 32'h0; m_valid = 1'b0; m_cs = 0; m_cf = 0;
    endtask

    // one cycle: drive at negedge, check just after, model the rising edge, wait next negedge
    task automatic step(input logic [31:0] inst, input logic [4:0] erd, input logic ewe,
                        input logic [4:0] mrd, input logic mwe, input logic redir,
                        input logic [31:0] rpc, input logic r);
        logic exp_stall;
        inst_in = inst; EX_rd = erd; EX_RegWrite = ewe; MEM_rd = mrd; MEM_RegWrite = mwe;
        redirect = redir; redirect_pc = rpc; rst = r;
        #1;
        exp_stall = m_valid && !redir &&
                    ((ewe && reads_reg(m_ir, erd)) || (mwe && reads_reg(m_ir, mrd)));
        chk("IF_PC", IF_PC, m_pc);
        chk("ID_IR", ID_IR, m_ir);
        chk("ID_PCurrent", ID_PCurrent, m_pcur);
        chk("ID_valid", {31'd0, ID_valid}, {31'd0, m_valid});
        chk("Data_stall", {31'd0, Data_stall}, {31'd0, exp_stall});
        chk("ctrl_flush", {31'd0, ctrl_flush}, {31'd0, redir});
        chk("cnt_stall", cnt_stall, m_cs[31:0]);
        chk("cnt_flush", cnt_flush, m_cf[31:0]);
        last_stall = exp_stall; last_valid = m_valid; last_ir = m_ir;
        if (r) begin
            model_reset();
        end else begin
            if (exp_stall && m_cs < 64'hFFFF_FFFF) m_cs++;
            if (redir && m_cf < 64'hFFFF_FFFF) m_cf++;
            if (redir) begin
                m_pcur = m_pc; m_pc = rpc & ~32'd3; m_ir = 32'h0; m_valid = 1'b0;
            end else if (!exp_stall) begin
                m_pcur = m_pc; m_pc = m_pc + 32'd4; m_ir = inst; m_valid = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] rnd;
        logic [6:0]  ops [8];
        ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b0010011, 7'b0000011};
        rnd = $urandom;
        return {rnd[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), rnd[14:12],
                5'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
    endfunction

    initial begin
        logic [4:0] bex_rd, bmem_rd;
        logic       bex_we, bmem_we, rr, rd_;
        logic [31:0] ri;

        // power-up reset
        rst = 1'b1; inst_in = 32'h0; EX_rd = 5'd0; EX_RegWrite = 1'b0; MEM_rd = 5'd0;
        MEM_RegWrite = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        s_rst = 1'b1; s_inst = 32'h0; s_ex_rd = 5'd0; s_ex_we = 1'b0; s_mem_rd = 5'd0;
        s_mem_we = 1'b0; s_redirect = 1'b0; s_redirect_pc = 32'h0;
        model_reset();
        @(negedge clk); @(negedge clk);

        // sequential fetch: IF_PC 0,4,8,C
        step(ADDI_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(ADDI_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(ADDI_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq_pc_c", IF_PC, 32'h0000_000C);
        chk("seq_pcur_8", ID_PCurrent, 32'h0000_0008);

        // RAW on rs1: EX distance, then MEM distance, then released
        step(ADD_X3_X1_X2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(ADDI_NOP, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(ADDI_NOP, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_hold_ir", ID_IR, ADD_X3_X1_X2);
        chk("stall_hold_pc", IF_PC, 32'h0000_0010);
        step(ADDI_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("cnt_stall_two", cnt_stall, 32'd2);

        // lui ignores rs1 field; x0 never hazards
        step(LUI_X5_8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(ADD_X3_X0_X2, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(ADD_X3_X1_X2, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("x0_no_stall_cnt", cnt_stall, 32'd2);

        // redirect while hazarding: squash, aligned target
        step(ADDI_NOP, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        chk("redir_pc", IF_PC, 32'h0000_0100);
        chk("redir_ir", ID_IR, 32'h0);
        chk("redir_valid", {31'd0, ID_valid}, 32'd0);
        chk("redir_cnt", cnt_flush, 32'd1);

        // PC wrap
        step(ADDI_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        chk("wrap_top", IF_PC, 32'hFFFF_FFFC);
        step(ADDI_NOP, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_zero", IF_PC, 32'h0);

        // reset in the middle of a stall
        step(ADD_X3_X1_X2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(ADDI_NOP, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(ADDI_NOP, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_pc", IF_PC, 32'h0);
        chk("rst_ir", ID_IR, 32'h0);
        chk("rst_cnt_stall", cnt_stall, 32'd0);
        chk("rst_cnt_flush", cnt_flush, 32'd0);

        // randomized traffic with a simple downstream pipeline feeding EX/MEM
        bex_rd = 5'd0; bex_we = 1'b0; bmem_rd = 5'd0; bmem_we = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ri  = rand_inst();
            rd_ = ($urandom_range(0, 9) == 0);
            rr  = ($urandom_range(0, 99) == 0);
            step(ri, bex_rd, bex_we, bmem_rd, bmem_we, rd_, $urandom, rr);
            bmem_rd = bex_rd; bmem_we = bex_we;
            if (rr || rd_ || last_stall || !last_valid) begin
                bex_rd = 5'd0; bex_we = 1'b0;
            end else begin
                bex_rd = last_ir[11:7]; bex_we = writes_reg(last_ir);
            end
        end

        // saturation on the 4-bit counter instance
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0; s_inst = ADD_X3_X1_X2;
        @(negedge clk);
        s_ex_rd = 5'd1; s_ex_we = 1'b1;
        repeat (20) @(negedge clk);
        chk("sat_stall_active", {31'd0, s_stall}, 32'd1);
        chk("sat_cnt_stall", {28'd0, s_cnt_stall}, 32'h0000_000F);
        s_redirect = 1'b1; s_redirect_pc = 32'h0000_0040;
        repeat (20) @(negedge clk);
        chk("sat_cnt_flush", {28'd0, s_cnt_flush}, 32'h0000_000F);
        chk("sat_cnt_stall_hold", {28'd0, s_cnt_stall}, 32'h0000_000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
